// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - IEEE 802.3 clause-22 MDIO management master
module mdio_master #(
    parameter int CLK_DIV     = 20,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdo,
    output logic        mdoEn,
    input  logic        mdi
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [9:0] DIV_LAST  = 10'(CLK_DIV - 1);
    localparam logic [5:0] FIRST_BIT = PREAMBLE_EN ? 6'd0 : 6'd32;

    state_t      state, state_nxt;
    logic [63:0] frame;
    logic        is_write;
    logic [5:0]  bit_idx;
    logic [9:0]  div_cnt;
    logic        mdc_q;
    logic [15:0] rdata;
    logic        err_q;
    logic        mdi_meta, mdi_sync;
    logic        accept, tick, mdc_rise, mdc_fall;

    assign accept   = cmd_valid && cmd_ready;
    assign tick     = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign mdc_rise = tick && !mdc_q;
    assign mdc_fall = tick && mdc_q;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_rdata = rdata;
    assign rsp_err   = err_q;
    assign mdc       = mdc_q;

    // Output enable is decoded from state so an async reset releases the pad at once.
    assign mdoEn = (state == SHIFT) && ((bit_idx < 6'd46) || is_write);
    assign mdo   = mdoEn && frame[6'd63 - bit_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (mdc_fall && (bit_idx == 6'd63)) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mdi_meta <= 1'b0;
            mdi_sync <= 1'b0;
            frame    <= '0;
            is_write <= 1'b0;
            bit_idx  <= '0;
            div_cnt  <= '0;
            mdc_q    <= 1'b0;
            rdata    <= '0;
            err_q    <= 1'b0;
        end else begin
            mdi_meta <= mdi;
            mdi_sync <= mdi_meta;
            if (accept) begin
                frame    <= {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10,
                             cmd_phy_addr, cmd_reg_addr, cmd_write ? 2'b10 : 2'b00,
                             cmd_write ? cmd_wdata : 16'h0000};
                is_write <= cmd_write;
                bit_idx  <= FIRST_BIT;
                div_cnt  <= '0;
                mdc_q    <= 1'b0;
                rdata    <= '0;
                err_q    <= 1'b0;
            end else if (state == SHIFT) begin
                if (tick) begin
                    div_cnt <= '0;
                    mdc_q   <= !mdc_q;
                end else begin
                    div_cnt <= div_cnt + 10'd1;
                end
                // PHY launches read data after a rising edge, so sample on the next rise.
                if (mdc_rise && !is_write) begin
                    if (bit_idx == 6'd47) begin
                        err_q <= mdi_sync;
                    end else if (bit_idx >= 6'd48) begin
                        rdata <= {rdata[14:0], mdi_sync};
                    end
                end
                if (mdc_fall && (bit_idx != 6'd63)) begin
                    bit_idx <= bit_idx + 6'd1;
                end
            end
        end
    end

endmodule
